// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (hpos/vpos counters, registered
// sync/blank decodes, line/frame start pulses, optional frame counter).
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the completed-frame
// counter; otherwise frame_cnt is tied to zero and no counter register exists.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned H_W       = 10,
  parameter int unsigned V_W       = 10,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               resync,
  output logic [H_W-1:0]     hpos,
  output logic [V_W-1:0]     vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_W-1:0] hpos_q, hpos_d;
  logic [V_W-1:0] vpos_q, vpos_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           disp_q, disp_d;
  logic           lstart_q, lstart_d;
  logic           fstart_q, fstart_d;
  logic           h_wrap, v_wrap;

  assign h_wrap = (hpos_q == H_LAST);
  assign v_wrap = (vpos_q == V_LAST);

  // Next-state: decodes sample the pre-advance position, so with resync and
  // ena together the outputs reflect the old position while counters restart.
  always_comb begin
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    disp_d   = disp_q;
    lstart_d = 1'b0;
    fstart_d = 1'b0;
    if (ena) begin
      hsync_d  = (hpos_q >= HS_FIRST && hpos_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = (vpos_q >= VS_FIRST && vpos_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
      disp_d   = (hpos_q < H_ACT_END) && (vpos_q < V_ACT_END);
      lstart_d = !resync && (hpos_q == '0);
      fstart_d = !resync && (hpos_q == '0) && (vpos_q == '0);
    end
    if (resync) begin
      hpos_d = '0;
      vpos_d = '0;
    end else if (ena) begin
      hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
      end
    end
  end

  // Position counters and registered decodes with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      disp_q   <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      disp_q   <= disp_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_cnt_q;

  assign frame_tick = ena && !resync && h_wrap && v_wrap;

  // Completed-frame counter, wraps modulo 2^FRAME_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, linear-position reference model,
// per-cycle comparison plus hand-computed checkpoints.
module tb_vga_timing_gen;

  localparam int HA = 6, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 13
  localparam int VT = VA + VF + VS + VB;   // 9
  localparam int FL = HT * VT;             // 117
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b0;
  localparam int FW = 2;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, ena, resync;
  logic [3:0]    hpos;
  logic [3:0]    vpos;
  logic          hsync, vsync, display_on, line_start, frame_start;
  logic [FW-1:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .H_W(4), .V_W(4), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .resync(resync),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: linear position within the frame plus expected registers.
  int   m_pos, m_fc;
  logic m_hs, m_vs, m_de, m_ls, m_fs;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_fc = 0;
    m_hs = ~HPOL; m_vs = ~VPOL; m_de = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs that edge will see.
  function automatic void model_step(input logic e, input logic rs);
    int h, v;
    h = m_pos % HT;
    v = m_pos / HT;
    if (e) begin
      m_hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
      m_vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
      m_de = (h < HA) && (v < VA);
      m_ls = !rs && (h == 0);
      m_fs = !rs && (m_pos == 0);
      if (!rs && m_pos == FL - 1) m_fc = m_fc + 1;
      m_pos = rs ? 0 : (m_pos + 1) % FL;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (rs) m_pos = 0;
    end
  endfunction

  // Compare every cycle on the falling edge, then advance the model; inputs
  // only change shortly after rising edges, so they are stable here.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("hpos", int'(hpos), m_pos % HT);
    chk("vpos", int'(vpos), m_pos / HT);
    chk("hsync", int'(hsync), int'(m_hs));
    chk("vsync", int'(vsync), int'(m_vs));
    chk("display_on", int'(display_on), int'(m_de));
    chk("line_start", int'(line_start), int'(m_ls));
    chk("frame_start", int'(frame_start), int'(m_fs));
    chk("frame_cnt", int'(frame_cnt), FC_EN ? (m_fc % (1 << FW)) : 0);
    if (rst_n) model_step(ena, resync);
  end

  int c_de, c_hs, c_vs, c_ls, c_fs;

  initial begin
    rst_n = 1'b1; ena = 1'b0; resync = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hpos", int'(hpos), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_display_on", int'(display_on), 0);
    rst_n = 1'b1;
    ena   = 1'b1;

    // One full frame of continuous enable from reset release.
    c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
    for (int c = 1; c <= FL; c++) begin
      @(posedge clk);
      #2;
      if (display_on) c_de++;
      if (hsync == HPOL) c_hs++;
      if (vsync == VPOL) c_vs++;
      if (line_start) c_ls++;
      if (frame_start) c_fs++;
      if (c == 1) begin
        chk("first_hpos", int'(hpos), 1);
        chk("first_frame_start", int'(frame_start), 1);
      end
      if (c == 8)  chk("hsync_before", int'(hsync), 0);
      if (c == 9)  chk("hsync_first", int'(hsync), 1);
      if (c == 12) chk("hsync_after", int'(hsync), 0);
    end
    chk("de_per_frame", c_de, 24);
    chk("hsync_per_frame", c_hs, 27);
    chk("vsync_per_frame", c_vs, 26);
    chk("lines_per_frame", c_ls, 9);
    chk("frames_per_frame", c_fs, 1);
    chk("frame_cnt_1", int'(frame_cnt), FC_EN ? 1 : 0);

    // Four more frames: counter wraps 1->2->3->0->1.
    repeat (4 * FL) @(posedge clk);
    #2;
    chk("frame_cnt_wrap", int'(frame_cnt), FC_EN ? 1 : 0);
    repeat (31) @(posedge clk);
    #2;
    chk("pre_resync_hpos", int'(hpos), 5);
    chk("pre_resync_vpos", int'(vpos), 2);

    // Resync with ena: decodes from (5,2), counters restart, no pulses.
    resync = 1'b1;
    @(posedge clk);
    #2;
    resync = 1'b0;
    chk("resync_hpos", int'(hpos), 0);
    chk("resync_vpos", int'(vpos), 0);
    chk("resync_line_start", int'(line_start), 0);
    chk("resync_display_on", int'(display_on), 1);
    chk("resync_frame_cnt", int'(frame_cnt), FC_EN ? 1 : 0);
    @(posedge clk);
    #2;
    chk("post_resync_frame_start", int'(frame_start), 1);

    // Resync without ena.
    ena = 1'b0; resync = 1'b1;
    @(posedge clk);
    #2;
    chk("resync_noena_hpos", int'(hpos), 0);
    chk("resync_noena_frame_start", int'(frame_start), 0);
    ena = 1'b1; resync = 1'b0;
    @(posedge clk);
    #2;
    chk("resync_noena_next_fs", int'(frame_start), 1);

    // Asynchronous reset in the middle of a frame.
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hpos", int'(hpos), 0);
    chk("async_vpos", int'(vpos), 0);
    chk("async_vsync", int'(vsync), 1);
    chk("async_display_on", int'(display_on), 0);
    chk("async_frame_cnt", int'(frame_cnt), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Randomised enable/resync/reset against the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if ((i / 500) % 2 == 0) ena = ($urandom_range(0, 1) == 1);
      else                    ena = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 59) == 0);
      rst_n  = ($urandom_range(0, 799) != 0);
    end
    rst_n = 1'b1; ena = 1'b0; resync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
